board_update_sequencer: RTL
===========================

BOARD_UPDATE_SEQUENCER -- requirements
Module: board_update_sequencer

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 init_req  input  1  one-cycle request to reload the starting board.
REQ-004 cmd_valid  input  1  move command valid.
REQ-005 cmd_ready  output  1  high only in IDLE when init_req is low.
REQ-006 cmd_src, cmd_dst, cmd_cap  input  5 each  square indices 0..31 for source, destination and captured piece.
REQ-007 cmd_capture  input  1  capture square write enabled.
REQ-008 cmd_piece  input  8  piece code for the destination.
REQ-009 locX_state, locY_state  output  8 each  pixel origin of the square being written.
REQ-010 update_state  output  8  state value to write.
REQ-011 wea_state_ram  output  1  write strobe to the state RAM stage.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 move_done  output  1  one-cycle pulse when a move sequence completes.

Function
REQ-014 Piece codes SHALL be: 8'h00 empty, 8'h01 red man, 8'h02 black man, 8'h03 red king, 8'h04 black king.
REQ-015 Index mapping SHALL be: row = idx[4:2], col = 2*idx[1:0] + (row even ? 1 : 0), locX_state = col*14, locY_state = row*14, in 8-bit arithmetic. Examples: idx 0 -> (0x0E,0x00); idx 4 -> (0x00,0x0E); idx 31 -> (0x54,0x62).
REQ-016 Every write SHALL take two cycles, SETUP then STROBE.
- SETUP: loc and data driven, wea_state_ram=0.
- STROBE: the same loc and data held, wea_state_ram=1.
- When no STROBE is active, loc and data SHALL hold their last values.
REQ-017 FSM states SHALL be INIT_SETUP, INIT_WR, IDLE, DST_SETUP, DST_WR, SRC_SETUP, SRC_WR, CAP_SETUP, CAP_WR.
REQ-018 INIT SHALL write squares 0..31 in ascending order using a 5-bit counter.
- Squares 0..11 get 8'h02, 12..19 get 8'h00, 20..31 get 8'h01.
- INIT takes 64 cycles, then enters IDLE.
REQ-019 In IDLE, init_req=1 SHALL enter INIT_SETUP with counter 0. init_req has priority over cmd_valid in the same cycle, and cmd_ready=0 in that cycle.
REQ-020 A command SHALL be accepted when cmd_valid && cmd_ready.
- All cmd_* inputs are registered on acceptance.
- Later input changes have no effect on the accepted move.
REQ-021 Move sequence SHALL be: DST (write the piece code) -> SRC (write 8'h00) -> CAP (write 8'h00, only if cmd_capture) -> IDLE.
- move_done pulses in the cycle after the last STROBE, coincident with the return to IDLE.
REQ-022 Skip rules:
- SRC writes are skipped if src==dst.
- CAP writes are skipped if cmd_capture=0, cap==dst, or cap==src.
- A skipped write consumes no cycles.
REQ-023 Latency from acceptance to move_done SHALL be 2 cycles per performed write plus 1 cycle: 7 cycles for a capture move, 5 for a plain move.
REQ-024 init_req and cmd_valid outside IDLE SHALL be ignored and not queued.
REQ-025 Consecutive commands SHALL be accepted back-to-back: cmd_ready is high in the move_done cycle, and the next SETUP starts the following cycle.

Reset
REQ-026 While reset_n=0, outputs SHALL be: loc/data=0, wea_state_ram=0, cmd_ready=0, busy=1, move_done=0, counter=0, state=INIT_SETUP.
REQ-027 Reset asserted mid-INIT or mid-move SHALL abort immediately; the partial move is discarded.
REQ-028 On reset release, INIT SHALL restart at square 0 on the first clock edge.

Configuration
REQ-029 With KING_PROMOTE_EN defined, the destination value SHALL be promoted:
- 8'h01 written to row 0 becomes 8'h03.
- 8'h02 written to row 7 becomes 8'h04.
- All other codes pass unchanged.
REQ-030 Without KING_PROMOTE_EN, cmd_piece SHALL be written unmodified.

Verification
REQ-031 Reset release -> 64 cycles of writes:
- idx 0 at (0x0E,0x00) with 02; idx 12 at (0x00,0x2A) with 00; idx 31 at (0x54,0x62) with 01.
- cmd_ready rises at cycle 64.
REQ-032 Move src=9, dst=13, piece=02, no capture:
- Writes (0x1C,0x2A)=02, then (0x2A,0x1C)=00.
- move_done 5 cycles after acceptance.
REQ-033 Capture move src=22, dst=13, cap=17, piece=01:
- Three strobes in order dst, src, cap.
- move_done at cycle 7.
REQ-034 Same-cycle init_req=1 and cmd_valid=1 in IDLE -> command not accepted, INIT runs.
REQ-035 reset_n pulsed low during SRC_SETUP -> wea_state_ram=0 at once, INIT restarts at square 0, no move_done pulse.
REQ-036 KING_PROMOTE_EN: piece 01 to dst=2 -> writes 03 at (0x46,0x00). Without the macro -> writes 01.

Source files
------------

// File: rtl/board_update_sequencer_if.sv
// Command handshake and state-RAM write bus for board_update_sequencer.
// master = command source / RAM stage side, slave = sequencer side.
interface board_update_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_src;
  logic [4:0] cmd_dst;
  logic [4:0] cmd_cap;
  logic       cmd_capture;
  logic [7:0] cmd_piece;
  logic [7:0] locX_state;
  logic [7:0] locY_state;
  logic [7:0] update_state;
  logic       wea_state_ram;

  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_cap, cmd_capture, cmd_piece,
    input  cmd_ready, locX_state, locY_state, update_state, wea_state_ram
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_cap, cmd_capture, cmd_piece,
    output cmd_ready, locX_state, locY_state, update_state, wea_state_ram
  );
endinterface

// File: rtl/board_update_sequencer.sv
// Sequences checkers-board writes (initial board load and move updates) into the state RAM stage.
// Optional KING_PROMOTE_EN: promote men reaching the far row to kings on the destination write.
//
// state      | meaning
// INIT_SETUP | present square cnt of the starting board, strobe low
// INIT_WR    | strobe square cnt, advance counter
// IDLE       | wait for init_req or a move command
// DST_SETUP  | present destination square with piece code
// DST_WR     | strobe destination
// SRC_SETUP  | present source square with empty code
// SRC_WR     | strobe source
// CAP_SETUP  | present captured square with empty code
// CAP_WR     | strobe captured square
module board_update_sequencer (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           init_req,
  board_update_sequencer_if.slave        bus,
  output logic                           busy,
  output logic                           move_done
);

  typedef enum logic [3:0] {
    INIT_SETUP, INIT_WR, IDLE, DST_SETUP, DST_WR,
    SRC_SETUP, SRC_WR, CAP_SETUP, CAP_WR
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic [4:0] src_q, dst_q, cap_q;
  logic       capture_q;
  logic [7:0] piece_q;
  logic       accept, src_en, cap_en, done_nxt;
  logic       in_write, strobe;
  logic [4:0] wr_idx;
  logic [7:0] wr_data, dst_data;
  logic [2:0] row;
  logic [3:0] col;
  logic [7:0] loc_x, loc_y;
  logic [7:0] loc_x_q, loc_y_q, data_q;

  assign accept = (state == IDLE) && !init_req && bus.cmd_valid;
  assign src_en = (src_q != dst_q);
  assign cap_en = capture_q && (cap_q != dst_q) && (cap_q != src_q);

  always_comb begin
    dst_data = piece_q;
`ifdef KING_PROMOTE_EN
    if (piece_q == 8'h01 && dst_q[4:2] == 3'd0)
      dst_data = 8'h03;
    else if (piece_q == 8'h02 && dst_q[4:2] == 3'd7)
      dst_data = 8'h04;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT_SETUP;
      cnt       <= 5'd0;
      move_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      move_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      INIT_SETUP: state_nxt = INIT_WR;
      INIT_WR: begin
        cnt_nxt   = cnt + 5'd1;
        state_nxt = (cnt == 5'd31) ? IDLE : INIT_SETUP;
      end
      IDLE: begin
        // init_req wins over a simultaneous command
        if (init_req) begin
          state_nxt = INIT_SETUP;
          cnt_nxt   = 5'd0;
        end else if (bus.cmd_valid) begin
          state_nxt = DST_SETUP;
        end
      end
      DST_SETUP: state_nxt = DST_WR;
      DST_WR: begin
        if (src_en)
          state_nxt = SRC_SETUP;
        else if (cap_en)
          state_nxt = CAP_SETUP;
        else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      SRC_SETUP: state_nxt = SRC_WR;
      SRC_WR: begin
        if (cap_en)
          state_nxt = CAP_SETUP;
        else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      CAP_SETUP: state_nxt = CAP_WR;
      CAP_WR: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: begin
        state_nxt = INIT_SETUP;
        cnt_nxt   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q     <= 5'd0;
      dst_q     <= 5'd0;
      cap_q     <= 5'd0;
      capture_q <= 1'b0;
      piece_q   <= 8'h00;
    end else if (accept) begin
      src_q     <= bus.cmd_src;
      dst_q     <= bus.cmd_dst;
      cap_q     <= bus.cmd_cap;
      capture_q <= bus.cmd_capture;
      piece_q   <= bus.cmd_piece;
    end
  end

  always_comb begin
    wr_idx   = cnt;
    wr_data  = 8'h00;
    in_write = 1'b1;
    case (state)
      INIT_SETUP, INIT_WR: begin
        wr_idx  = cnt;
        wr_data = (cnt < 5'd12) ? 8'h02 : ((cnt < 5'd20) ? 8'h00 : 8'h01);
      end
      DST_SETUP, DST_WR: begin
        wr_idx  = dst_q;
        wr_data = dst_data;
      end
      SRC_SETUP, SRC_WR: wr_idx = src_q;
      CAP_SETUP, CAP_WR: wr_idx = cap_q;
      default:           in_write = 1'b0;
    endcase
  end

  assign strobe = (state == INIT_WR) || (state == DST_WR) ||
                  (state == SRC_WR)  || (state == CAP_WR);

  // playable squares sit on odd columns in even rows, even columns in odd rows
  assign row   = wr_idx[4:2];
  assign col   = {1'b0, wr_idx[1:0], 1'b0} + {3'b000, ~row[0]};
  assign loc_x = {4'b0000, col} * 8'd14;
  assign loc_y = {5'b00000, row} * 8'd14;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loc_x_q <= 8'h00;
      loc_y_q <= 8'h00;
      data_q  <= 8'h00;
    end else if (in_write) begin
      loc_x_q <= loc_x;
      loc_y_q <= loc_y;
      data_q  <= wr_data;
    end
  end

  // the reset state is already INIT_SETUP, so the live path is gated off while reset is held
  assign bus.locX_state    = (reset_n && in_write) ? loc_x   : loc_x_q;
  assign bus.locY_state    = (reset_n && in_write) ? loc_y   : loc_y_q;
  assign bus.update_state  = (reset_n && in_write) ? wr_data : data_q;
  assign bus.wea_state_ram = strobe;
  assign bus.cmd_ready     = (state == IDLE) && !init_req;
  assign busy              = (state != IDLE);

endmodule
